// File: rtl/riscv_biu_pkg.sv
// Shared AHB3-Lite encodings and the bus-interface state enum for the data-side BIU.
package riscv_biu_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  // Undefined-length INCR is issued as a single beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] bt);
    case (bt)
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd1;
    endcase
  endfunction

  function automatic logic burst_is_wrap(input logic [2:0] bt);
    return (bt == HBURST_WRAP4) || (bt == HBURST_WRAP8) || (bt == HBURST_WRAP16);
  endfunction

endpackage

// File: rtl/riscv_biu_burst_ctr.sv
// Beat counter and next-address generator for fixed-length INCR/WRAP bursts.
module riscv_biu_burst_ctr
  import riscv_biu_pkg::*;
#(
  parameter int PHYS_ADDR_SIZE = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_adv,
  input  logic [PHYS_ADDR_SIZE-1:0] i_adr,
  input  logic [2:0]                i_size,
  input  logic [2:0]                i_burst,
  output logic [PHYS_ADDR_SIZE-1:0] o_adr,
  output logic                      o_last
);

  logic [4:0]                r_cnt;
  logic [PHYS_ADDR_SIZE-1:0] r_adr;
  logic [2:0]                r_size;
  logic [2:0]                r_burst;

  // WRAP keeps the bits above the (beats << size) boundary and wraps the rest.
  function automatic logic [PHYS_ADDR_SIZE-1:0] next_adr(
    input logic [PHYS_ADDR_SIZE-1:0] a,
    input logic [2:0]                sz,
    input logic [2:0]                bt
  );
    logic [PHYS_ADDR_SIZE-1:0] step, incr, mask;
    step = PHYS_ADDR_SIZE'(1) << sz;
    incr = a + step;
    mask = (PHYS_ADDR_SIZE'(burst_beats(bt)) << sz) - PHYS_ADDR_SIZE'(1);
    return burst_is_wrap(bt) ? ((a & ~mask) | (incr & mask)) : incr;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_adr   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (i_start) begin
      r_cnt   <= burst_beats(i_burst) - 5'd1;
      r_adr   <= next_adr(i_adr, i_size, i_burst);
      r_size  <= i_size;
      r_burst <= i_burst;
    end else if (i_adv) begin
      r_cnt   <= r_cnt - 5'd1;
      r_adr   <= next_adr(r_adr, r_size, r_burst);
    end
  end

  assign o_adr  = r_adr;
  assign o_last = (r_cnt == 5'd1);

endmodule

// File: rtl/riscv_dbiu_ahb3lite.sv
// Data-side BIU: core biu_* strobe/ack to AHB3-Lite master with overlapped address/data phases.
// Fixed-length bursts are enabled by defining RV12_BIU_BURST_EN; otherwise every beat is SINGLE/NONSEQ.
module riscv_dbiu_ahb3lite
  import riscv_biu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      biu_stb,
  output logic                      biu_stb_ack,
  input  logic [PHYS_ADDR_SIZE-1:0] biu_adri,
  output logic [PHYS_ADDR_SIZE-1:0] biu_adro,
  input  logic [2:0]                biu_size,
  input  logic [2:0]                biu_type,
  input  logic                      biu_lock,
  input  logic                      biu_we,
  input  logic [XLEN-1:0]           biu_di,
  output logic [XLEN-1:0]           biu_do,
  output logic                      biu_wack,
  output logic                      biu_rack,
  output logic                      biu_err,
  input  logic                      biu_is_cacheable,
  input  logic                      biu_is_instruction,
  input  logic [1:0]                biu_prv,
  output logic [PHYS_ADDR_SIZE-1:0] HADDR,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic [1:0]                HTRANS,
  output logic                      HMASTLOCK,
  output logic [XLEN-1:0]           HWDATA,
  input  logic [XLEN-1:0]           HRDATA,
  input  logic                      HREADY,
  input  logic                      HRESP
);

  state_t                    r_state;
  logic                      r_dp_valid;
  logic                      r_dp_we;
  logic [PHYS_ADDR_SIZE-1:0] r_dp_adr;
  logic [XLEN-1:0]           r_hwdata;
  logic                      r_hwrite;
  logic [2:0]                r_hsize;
  logic [2:0]                r_hburst;
  logic [3:0]                r_hprot;

  logic                      w_err_first;
  logic                      w_in_burst;
  logic                      w_new;
  logic                      w_seq;
  logic                      w_accept;
  logic                      w_done;
  logic                      w_is_burst_req;
  logic                      w_last;
  logic [PHYS_ADDR_SIZE-1:0] w_burst_adr;
  logic [3:0]                w_prot_in;

  assign w_err_first = r_dp_valid & HRESP & ~HREADY;
  assign w_in_burst  = (r_state == ST_BURST);
  assign w_new       = ~rst & (r_state == ST_IDLE) & biu_stb & HREADY;
  assign w_seq       = ~rst & w_in_burst & HREADY;
  assign w_accept    = w_new | w_seq;
  assign w_prot_in   = {biu_is_cacheable, 1'b0, |biu_prv, ~biu_is_instruction};

`ifdef RV12_BIU_BURST_EN
  assign w_is_burst_req = (burst_beats(biu_type) != 5'd1);

  riscv_biu_burst_ctr #(
    .PHYS_ADDR_SIZE(PHYS_ADDR_SIZE)
  ) u_burst_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_new & w_is_burst_req),
    .i_adv  (w_seq),
    .i_adr  (biu_adri),
    .i_size (biu_size),
    .i_burst(biu_type),
    .o_adr  (w_burst_adr),
    .o_last (w_last)
  );
`else
  logic w_unused_type;
  assign w_unused_type  = ^biu_type;
  assign w_is_burst_req = 1'b0;
  assign w_burst_adr    = '0;
  assign w_last         = 1'b1;
`endif

  // Address phase: live request inputs when idle, latched attributes during a burst.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_BYTE;
    HBURST = HBURST_SINGLE;
    HPROT  = 4'd0;
    if (w_new)      HTRANS = HTRANS_NONSEQ;
    else if (w_seq) HTRANS = HTRANS_SEQ;
    if (!rst) begin
      if (w_in_burst) begin
        HADDR  = w_burst_adr;
        HWRITE = r_hwrite;
        HSIZE  = r_hsize;
        HBURST = r_hburst;
        HPROT  = r_hprot;
      end else begin
        HADDR  = biu_adri;
        HWRITE = biu_we;
        HSIZE  = biu_size;
        HBURST = w_is_burst_req ? biu_type : HBURST_SINGLE;
        HPROT  = w_prot_in;
      end
    end
  end

  assign HMASTLOCK   = biu_lock;
  assign biu_stb_ack = w_accept;

  // Data phase / completion.
  assign w_done   = ~rst & r_dp_valid & HREADY;
  assign biu_wack = w_done & r_dp_we;
  assign biu_rack = w_done & ~r_dp_we;
  assign biu_err  = w_done & (r_state == ST_ERR);
  assign biu_adro = r_dp_adr;
  assign biu_do   = HRDATA;
  assign HWDATA   = r_hwdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dp_valid <= 1'b0;
      r_dp_we    <= 1'b0;
      r_dp_adr   <= '0;
      r_hwdata   <= '0;
      r_hwrite   <= 1'b0;
      r_hsize    <= '0;
      r_hburst   <= '0;
      r_hprot    <= '0;
    end else begin
      if (HREADY) begin
        r_dp_valid <= w_accept;
        if (w_accept) begin
          r_dp_we  <= HWRITE;
          r_dp_adr <= HADDR;
          r_hwdata <= biu_di;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_err_first) begin
            r_state <= ST_ERR;
          end else if (w_new && w_is_burst_req) begin
            r_state  <= ST_BURST;
            r_hwrite <= biu_we;
            r_hsize  <= biu_size;
            r_hburst <= biu_type;
            r_hprot  <= w_prot_in;
          end
        end
        ST_BURST: begin
          // An error abandons the remaining beats of the burst.
          if (w_err_first)          r_state <= ST_ERR;
          else if (w_seq && w_last) r_state <= ST_IDLE;
        end
        ST_ERR: begin
          if (HREADY) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
